note_envelope: RTL
==================

// Module: note_envelope
// PURPOSE
//   Amplitude envelope stage directly downstream of the note generator.
//   Takes the generator's signed sample, its phase index and the active noteid.
//   Applies a per-note attack/decay/sustain/release gain that steps once per waveform period.
//   Drives the scaled signed sample to the mixer/DAC path.
// PARAMETERS
//   AM_WIDTH      8      sample width, signed two's complement
//   THETA_WIDTH   8      phase index width
//   ATTACK_STEP   4096   gain increment per period in ATTACK
//   DECAY_NUM     1020   DECAY multiplier numerator, denominator 1024
//   SUSTAIN_LEVEL 16384  gain floor reached in DECAY, held while note stays on
//   RELEASE_NUM   960    RELEASE multiplier numerator, denominator 1024
//   RELEASE_FLOOR 64     gain below this in RELEASE forces gain 0, state IDLE
// PORTS
//   clk      in   1            system clock
//   rst_n    in   1            asynchronous reset, active low
//   noteid   in   8            active note, 0 = no note, clk domain
//   theta_in in   THETA_WIDTH  phase index from note generator, slow clock domain
//   am_in    in   AM_WIDTH     signed sample from note generator, slow clock domain
//   am_out   out  AM_WIDTH     signed enveloped sample, registered
//   gain     out  16           current envelope gain, unsigned, 65535 = unity
//   state    out  2            0 IDLE, 1 ATTACK, 2 DECAY, 3 RELEASE
//   busy     out  1            state != IDLE
// BEHAVIOUR
//   Reset (rst_n low, async): am_out=0, gain=0, state=IDLE, last_id=0, sync regs=0.
//   Input synchronisation:
//     theta_in and am_in each pass through 2 flops (th_s, am_s).
//     Both change far slower than clk.
//   wrap event: th_s==0 and previous th_s!=0; one clk pulse per period.
//   last_id: register loaded with noteid every clk.
//   Event priority in one cycle:
//     1. retrigger
//     2. note-off
//     3. wrap step
//     Lower-priority events in that cycle are dropped.
//   retrigger: noteid!=0 and noteid!=last_id.
//     Sets gain=0 and state=ATTACK from any state, including RELEASE.
//   note-off: noteid==0, last_id!=0, state!=IDLE.
//     Sets state=RELEASE; gain is unchanged that cycle.
//   Wrap step, by state:
//     ATTACK: gain = min(gain+ATTACK_STEP, 65535), 17-bit sum.
//       Enter DECAY in the same cycle the sum reaches or exceeds 65535.
//     DECAY: g = (gain*DECAY_NUM)>>10, 26-bit product.
//       gain = max(g, SUSTAIN_LEVEL). Stay in DECAY (sustain is DECAY at the floor).
//     RELEASE: g = (gain*RELEASE_NUM)>>10.
//       If g < RELEASE_FLOOR: gain=0 and state=IDLE, else gain=g.
//     IDLE: no change.
//   Output register, every clk:
//     p = am_s (sign-extended) * {1'b0,gain}, AM_WIDTH+17 bits signed.
//     am_out = (p >>> 16) truncated to AM_WIDTH bits.
//     Rounds toward -inf; cannot overflow.
//     am_out = 0 while state==IDLE.
//   Latency am_in -> am_out: 3 clk (2 sync + 1 output register).
//   Gain update -> am_out: 1 clk.
//   Mid-operation rst_n: immediate return to reset values; first retrigger after release starts ATTACK.
// TESTING
//   1 Reset: rst_n low mid-ATTACK
//       -> am_out=0, gain=0, state=0, busy=0 asynchronously, before the next clk edge.
//   2 Attack, defaults: noteid 0->60, wraps every 256 theta steps
//       -> gain 4096,8192,...; 16th wrap gives gain=65535, state=2.
//   3 Decay/sustain: continue wraps
//       -> each gain = prev*1020>>10 (65535->65279); clamps at 16384, stays state=2.
//   4 Release: noteid 60->0 at gain=16384
//       -> state=3; gain 15360,14400,...; reaches gain=0, state=0, am_out=0.
//   5 Retrigger and priority: noteid 60->62 during RELEASE, coincident with wrap
//       -> gain=0, state=1, wrap step dropped.
//   6 Scaling, gain held at 65535:
//       am_in=127 -> am_out=126; am_in=-128 -> am_out=-128.
//     Scaling, gain held at 32768:
//       am_in=-128 -> am_out=-64.
//     am_out appears 3 clk after am_in.

Source files
------------

// File: rtl/note_envelope.sv
// note_envelope
//   Amplitude envelope stage sitting right after the note generator. The
//   generator's sample and phase index are resynchronised into clk, a per-note
//   attack/decay/sustain/release gain is stepped once per waveform period
//   (phase wrap), and the sample is scaled by that gain for the mixer/DAC.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no note sounding, gain 0, am_out forced to 0
//   ATTACK| gain rises by ATTACK_STEP per period until it saturates at 65535
//   DECAY | gain scaled by DECAY_NUM/1024 per period, floored at SUSTAIN_LEVEL
//   RELEASE| gain scaled by RELEASE_NUM/1024 per period until below RELEASE_FLOOR
//
// Ports
//   clk      system clock
//   rst_n    asynchronous reset, active low
//   noteid   active note id (0 = no note), clk domain
//   theta_in phase index from the note generator, slow domain
//   am_in    signed sample from the note generator, slow domain
//   am_out   signed enveloped sample, registered
//   gain     current envelope gain, unsigned, 65535 = unity
//   state    envelope state: 0 IDLE, 1 ATTACK, 2 DECAY, 3 RELEASE
//   busy     high whenever state is not IDLE
module note_envelope #(
    parameter int AM_WIDTH      = 8,
    parameter int THETA_WIDTH   = 8,
    parameter int ATTACK_STEP   = 4096,
    parameter int DECAY_NUM     = 1020,
    parameter int SUSTAIN_LEVEL = 16384,
    parameter int RELEASE_NUM   = 960,
    parameter int RELEASE_FLOOR = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 noteid,
    input  logic [THETA_WIDTH-1:0]     theta_in,
    input  logic signed [AM_WIDTH-1:0] am_in,
    output logic signed [AM_WIDTH-1:0] am_out,
    output logic [15:0]                gain,
    output logic [1:0]                 state,
    output logic                       busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_DECAY   = 2'd2,
        ST_RELEASE = 2'd3
    } env_state_t;

    env_state_t state_q, state_d;
    logic [15:0] gain_q, gain_d;

    logic [THETA_WIDTH-1:0] th_m, th_s, th_prev;
    logic [AM_WIDTH-1:0]    am_m, am_s;
    logic [7:0]             last_id;

    logic        wrap, retrig, note_off;
    logic [16:0] attack_sum;
    logic [25:0] decay_prod, release_prod;
    logic [15:0] decay_g, release_g;
    logic signed [AM_WIDTH+16:0] prod;
    logic        unused_bits;

    // Two-flop synchronisers; th_prev holds the previous synchronised phase
    // so a wrap is seen as exactly one clk pulse per period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            th_m    <= '0;
            th_s    <= '0;
            th_prev <= '0;
            am_m    <= '0;
            am_s    <= '0;
            last_id <= '0;
        end else begin
            th_m    <= theta_in;
            th_s    <= th_m;
            th_prev <= th_s;
            am_m    <= am_in;
            am_s    <= am_m;
            last_id <= noteid;
        end
    end

    assign wrap     = (th_s == '0) && (th_prev != '0);
    assign retrig   = (noteid != 8'd0) && (noteid != last_id);
    assign note_off = (noteid == 8'd0) && (last_id != 8'd0) && (state_q != ST_IDLE);

    assign attack_sum   = {1'b0, gain_q} + 17'(ATTACK_STEP);
    assign decay_prod   = {10'd0, gain_q} * 26'(DECAY_NUM);
    assign release_prod = {10'd0, gain_q} * 26'(RELEASE_NUM);
    assign decay_g      = decay_prod[25:10];
    assign release_g    = release_prod[25:10];

    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        if (retrig) begin
            state_d = ST_ATTACK;
            gain_d  = 16'd0;
        end else if (note_off) begin
            state_d = ST_RELEASE;
        end else if (wrap) begin
            case (state_q)
                ST_ATTACK: begin
                    if (attack_sum >= 17'd65535) begin
                        gain_d  = 16'hFFFF;
                        state_d = ST_DECAY;
                    end else begin
                        gain_d = attack_sum[15:0];
                    end
                end
                ST_DECAY: begin
                    // Sustain is simply DECAY pinned at the floor.
                    gain_d = (decay_g < 16'(SUSTAIN_LEVEL)) ? 16'(SUSTAIN_LEVEL) : decay_g;
                end
                ST_RELEASE: begin
                    if (release_g < 16'(RELEASE_FLOOR)) begin
                        gain_d  = 16'd0;
                        state_d = ST_IDLE;
                    end else begin
                        gain_d = release_g;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gain_q  <= '0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
        end
    end

    // Gain is at most 65535/65536 of unity, so the floor-shifted product
    // always fits back into AM_WIDTH bits.
    assign prod = $signed({{17{am_s[AM_WIDTH-1]}}, am_s}) *
                  $signed({{(AM_WIDTH+1){1'b0}}, gain_q});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            am_out <= '0;
        end else if (state_q == ST_IDLE) begin
            am_out <= '0;
        end else begin
            am_out <= prod[AM_WIDTH+15:16];
        end
    end

    assign unused_bits = ^{prod[15:0], prod[AM_WIDTH+16], decay_prod[9:0], release_prod[9:0]};

    assign gain  = gain_q;
    assign state = state_q;
    assign busy  = (state_q != ST_IDLE);

endmodule
